bus_arbiter: RTL



---
 rtl/bus_arb_pkg.sv | 36 +++
 rtl/bus_watchdog.sv | 40 ++++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and helpers for the bus arbiter slice.
// Holds the arbiter state enum, a clog2 helper and the round-robin picker.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    HANDOFF = 2'd2
  } arb_state_t;

  localparam int MAX_M = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // First set bit scanning upward from last+1, wrapping mod n.
  // Scanning k downward lets the nearest candidate overwrite the others,
  // and k=n (last itself) has the lowest priority.
  function automatic int rr_pick(
    input logic [MAX_M-1:0] req,
    input int               n,
    input int               last
  );
    int idx;
    rr_pick = last;
    for (int k = n; k >= 1; k--) begin
      idx = (last + k) % n;
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: pending-access detect, timeout counter and abort pulse.
// Ports: clk, rst, rd_bus, wr_bus, fc_bus in; fire (comb), watchdog (reg) out.
module bus_watchdog
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_bus,
  input  logic wr_bus,
  input  logic fc_bus,
  output logic fire,
  output logic watchdog
);

  localparam int CNT_W = clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;
  logic             pending;

  // rd and wr together is an invalid cycle, not an access
  assign pending = (rd_bus ^ wr_bus) && !fc_bus;
  assign fire    = pending &&
                   (count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      watchdog <= 1'b0;
    end else begin
      watchdog <= fire;
      if (!pending || fire)
        count <= '0;
      else
        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus_req/bus_grant owner plus bus watchdog.
// Ports: clk, rst, bus_req, rd/wr/fc_bus in; bus_grant, watchdog, fault_id, fault_valid out.
// Option: define BUS_ARB_PARK_EN to park PARK_MASTER on the bus when idle.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int PARK_MASTER    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          bus_req,
  output logic [NUM_MASTERS-1:0]          bus_grant,
  input  logic                            rd_bus,
  input  logic                            wr_bus,
  input  logic                            fc_bus,
  output logic                            watchdog,
  output logic [clog2(NUM_MASTERS)-1:0]   fault_id,
  output logic                            fault_valid
);

  localparam int OWN_W = clog2(NUM_MASTERS);
  localparam logic [OWN_W-1:0] LAST_RST =
    OWN_W'(NUM_MASTERS - 1);

  arb_state_t             state;
  arb_state_t             state_n;
  logic [NUM_MASTERS-1:0] grant_n;
  logic [OWN_W-1:0]       last_owner;
  logic [OWN_W-1:0]       owner_n;
  logic [OWN_W-1:0]       winner;
  logic [MAX_M-1:0]       req_ext;
  logic                   fire;

  function automatic logic [NUM_MASTERS-1:0] onehot(
    input logic [OWN_W-1:0] i
  );
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign req_ext = MAX_M'(bus_req);
  assign winner  = OWN_W'(rr_pick(req_ext, NUM_MASTERS,
                                  int'(last_owner)));

`ifdef BUS_ARB_PARK_EN
  localparam logic [OWN_W-1:0] PARK_IDX = OWN_W'(PARK_MASTER);
`endif

  always_comb begin
    state_n = state;
    grant_n = bus_grant;
    owner_n = last_owner;
    unique case (state)
      IDLE: begin
        if (|bus_req) begin
`ifdef BUS_ARB_PARK_EN
          // Parked grant going to someone else: one zero
          // cycle for turnaround, then arbitrate from IDLE.
          if (bus_grant != '0 && winner != PARK_IDX) begin
            grant_n = '0;
          end else begin
            grant_n = onehot(winner);
            owner_n = winner;
            state_n = GRANTED;
          end
`else
          grant_n = onehot(winner);
          owner_n = winner;
          state_n = GRANTED;
`endif
        end else begin
`ifdef BUS_ARB_PARK_EN
          grant_n = onehot(PARK_IDX);
`else
          grant_n = '0;
`endif
        end
      end
      GRANTED: begin
        if (!bus_req[last_owner]) begin
          grant_n = '0;
          state_n = HANDOFF;
        end
      end
      HANDOFF: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus_grant   <= '0;
      last_owner  <= LAST_RST;
      fault_id    <= '0;
      fault_valid <= 1'b0;
    end else begin
      state      <= state_n;
      bus_grant  <= grant_n;
      last_owner <= owner_n;
      if (fire) begin
        fault_id    <= last_owner;
        fault_valid <= 1'b1;
      end
    end
  end

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .rd_bus  (rd_bus),
    .wr_bus  (wr_bus),
    .fc_bus  (fc_bus),
    .fire    (fire),
    .watchdog(watchdog)
  );

endmodule
